// File: rtl/pc_sequencer.sv
// Instruction-pointer sequencer with a multi-level return-address stack and RUN/FAULT control.
// Optional macro PC_SEQ_TRACE_EN adds oLastFrom, the IP before the most recent taken transfer.
module pc_sequencer #(
    parameter int                 ADDR_W       = 16,
    parameter int                 STACK_DEPTH  = 8,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = {ADDR_W{1'b0}}
) (
    input  logic                            Clock,
    input  logic                            Reset,
    input  logic                            iStall,
    input  logic                            iBranchTaken,
    input  logic                            iCall,
    input  logic                            iRet,
    input  logic [ADDR_W-1:0]               iTarget,
    input  logic                            iClearFault,
    output logic [ADDR_W-1:0]               oIP,
    output logic [$clog2(STACK_DEPTH):0]    oDepth,
    output logic                            oOverflow,
    output logic                            oUnderflow,
    output logic                            oFault
`ifdef PC_SEQ_TRACE_EN
    ,
    output logic [ADDR_W-1:0]               oLastFrom
`endif
);

    localparam int PTR_W   = $clog2(STACK_DEPTH);
    localparam int DEPTH_W = PTR_W + 1;
    localparam logic [DEPTH_W-1:0] FULL_C     = DEPTH_W'(STACK_DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE  = {{(DEPTH_W-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_W-1:0] DEPTH_ZERO = {DEPTH_W{1'b0}};
    localparam logic [ADDR_W-1:0]  IP_ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t               state_r, state_nxt_s;
    logic [ADDR_W-1:0]    ip_r, ip_nxt_s;
    logic [DEPTH_W-1:0]   depth_r, depth_nxt_s;
    logic                 ovf_r, ovf_nxt_s;
    logic                 unf_r, unf_nxt_s;
    logic                 push_s;
    logic [ADDR_W-1:0]    ret_addr_s;
    logic [DEPTH_W-1:0]   depth_dec_s;
    logic [DEPTH_W-1:0]   depth_inc_s;
    logic [PTR_W-1:0]     pop_idx_s;
    logic [PTR_W-1:0]     push_idx_s;
    logic [ADDR_W-1:0]    stack_r [STACK_DEPTH];

    // Stack pointer arithmetic and the return address a call would push
    always_comb begin
        depth_dec_s = depth_r - DEPTH_ONE;
        depth_inc_s = depth_r + DEPTH_ONE;
        pop_idx_s   = depth_dec_s[PTR_W-1:0];
        push_idx_s  = depth_r[PTR_W-1:0];
        ret_addr_s  = ip_r + IP_ONE;
    end

    // Next-state, next-IP and stack control; priority stall > ret > call > branch > sequential
    always_comb begin
        state_nxt_s = state_r;
        ip_nxt_s    = ip_r;
        depth_nxt_s = depth_r;
        ovf_nxt_s   = 1'b0;
        unf_nxt_s   = 1'b0;
        push_s      = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (iStall) begin
                    ip_nxt_s = ip_r;
                end else if (iRet) begin
                    if (depth_r != DEPTH_ZERO) begin
                        ip_nxt_s    = stack_r[pop_idx_s];
                        depth_nxt_s = depth_dec_s;
                    end else begin
                        unf_nxt_s   = 1'b1;
                        state_nxt_s = ST_FAULT;
                    end
                end else if (iCall) begin
                    if (depth_r != FULL_C) begin
                        push_s      = 1'b1;
                        ip_nxt_s    = iTarget;
                        depth_nxt_s = depth_inc_s;
                    end else begin
                        ovf_nxt_s   = 1'b1;
                        state_nxt_s = ST_FAULT;
                    end
                end else if (iBranchTaken) begin
                    ip_nxt_s = iTarget;
                end else begin
                    ip_nxt_s = ip_r + IP_ONE;
                end
            end
            ST_FAULT: begin
                if (iClearFault) begin
                    state_nxt_s = ST_RUN;
                    ip_nxt_s    = RESET_VECTOR;
                    depth_nxt_s = DEPTH_ZERO;
                end else begin
                    state_nxt_s = ST_FAULT;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                ip_nxt_s    = RESET_VECTOR;
                depth_nxt_s = DEPTH_ZERO;
            end
        endcase
    end

    // Control registers: state, IP, depth and the one-cycle fault pulses
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_RUN;
            ip_r    <= RESET_VECTOR;
            depth_r <= DEPTH_ZERO;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ip_r    <= ip_nxt_s;
            depth_r <= depth_nxt_s;
            ovf_r   <= ovf_nxt_s;
            unf_r   <= unf_nxt_s;
        end
    end

    // Return-address storage; contents are meaningless above depth, so no reset is needed
    always_ff @(posedge Clock) begin
        if (push_s) begin
            stack_r[push_idx_s] <= ret_addr_s;
        end
    end

    assign oIP        = ip_r;
    assign oDepth     = depth_r;
    assign oOverflow  = ovf_r;
    assign oUnderflow = unf_r;
    assign oFault     = (state_r == ST_FAULT);

`ifdef PC_SEQ_TRACE_EN
    logic              xfer_s;
    logic [ADDR_W-1:0] last_from_r;

    // A transfer is taken only when it actually redirects the IP in RUN
    always_comb begin
        if ((state_r == ST_RUN) && !iStall) begin
            if (iRet) begin
                xfer_s = (depth_r != DEPTH_ZERO);
            end else if (iCall) begin
                xfer_s = (depth_r != FULL_C);
            end else begin
                xfer_s = iBranchTaken;
            end
        end else begin
            xfer_s = 1'b0;
        end
    end

    // Source address of the most recent taken transfer
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            last_from_r <= RESET_VECTOR;
        end else if (xfer_s) begin
            last_from_r <= ip_r;
        end else begin
            last_from_r <= last_from_r;
        end
    end

    assign oLastFrom = last_from_r;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed steps then randomized traffic against a queue-based model.
module tb_pc_sequencer;

    localparam int AW = 16;
    localparam int SD = 8;
    localparam int DW = $clog2(SD) + 1;
    localparam logic [AW-1:0] RV = 16'h0000;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          iStall = 1'b0;
    logic          iBranchTaken = 1'b0;
    logic          iCall = 1'b0;
    logic          iRet = 1'b0;
    logic [AW-1:0] iTarget = 16'h0000;
    logic          iClearFault = 1'b0;
    logic [AW-1:0] oIP;
    logic [DW-1:0] oDepth;
    logic          oOverflow;
    logic          oUnderflow;
    logic          oFault;
`ifdef PC_SEQ_TRACE_EN
    logic [AW-1:0] oLastFrom;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [AW-1:0] m_ip;
    logic [AW-1:0] m_stack [$];
    logic          m_fault;
    logic          m_ovf;
    logic          m_unf;
    logic [AW-1:0] m_last;

    pc_sequencer #(.ADDR_W(AW), .STACK_DEPTH(SD), .RESET_VECTOR(RV)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iStall       (iStall),
        .iBranchTaken (iBranchTaken),
        .iCall        (iCall),
        .iRet         (iRet),
        .iTarget      (iTarget),
        .iClearFault  (iClearFault),
        .oIP          (oIP),
        .oDepth       (oDepth),
        .oOverflow    (oOverflow),
        .oUnderflow   (oUnderflow),
        .oFault       (oFault)
`ifdef PC_SEQ_TRACE_EN
        ,
        .oLastFrom    (oLastFrom)
`endif
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        assert (act === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_all();
        check("ip",        32'(oIP),        32'(m_ip));
        check("depth",     32'(oDepth),     32'(m_stack.size()));
        check("overflow",  32'(oOverflow),  32'(m_ovf));
        check("underflow", 32'(oUnderflow), 32'(m_unf));
        check("fault",     32'(oFault),     32'(m_fault));
`ifdef PC_SEQ_TRACE_EN
        check("last_from", 32'(oLastFrom),  32'(m_last));
`endif
    endtask

    task automatic model_reset();
        m_ip    = RV;
        m_stack.delete();
        m_fault = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_last  = RV;
    endtask

    task automatic model_edge();
        logic [AW-1:0] ra;
        if (Reset) begin
            model_reset();
        end else begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
            if (m_fault) begin
                if (iClearFault) begin
                    m_fault = 1'b0;
                    m_ip    = RV;
                    m_stack.delete();
                end
            end else if (iStall) begin
                m_ip = m_ip;
            end else if (iRet) begin
                if (m_stack.size() > 0) begin
                    m_last = m_ip;
                    m_ip   = m_stack.pop_back();
                end else begin
                    m_unf   = 1'b1;
                    m_fault = 1'b1;
                end
            end else if (iCall) begin
                if (m_stack.size() < SD) begin
                    ra     = m_ip + 16'd1;
                    m_last = m_ip;
                    m_stack.push_back(ra);
                    m_ip   = iTarget;
                end else begin
                    m_ovf   = 1'b1;
                    m_fault = 1'b1;
                end
            end else if (iBranchTaken) begin
                m_last = m_ip;
                m_ip   = iTarget;
            end else begin
                m_ip = m_ip + 16'd1;
            end
        end
    endtask

    // Drive one cycle of controls, advance the model at the edge and compare shortly after
    task automatic step(input logic st, input logic rt, input logic cl, input logic br,
                        input logic [AW-1:0] tg, input logic clr);
        iStall = st; iRet = rt; iCall = cl; iBranchTaken = br; iTarget = tg; iClearFault = clr;
        @(posedge Clock);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        logic [AW-1:0] tg;
        logic st, rt, cl, br, clr;
        model_reset();

        // Reset held across edges
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        Reset = 1'b0;

        // Five idle cycles count up from the reset vector
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

        // Asynchronous reset between edges
        #2 Reset = 1'b1;
        #1;
        model_reset();
        check_all();
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        Reset = 1'b0;

        // Call/return from 0x0010 to 0x0040
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0040, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);

        // Fill the stack, then overflow into FAULT
        for (int i = 0; i < SD + 1; i++) step(1'b0, 1'b0, 1'b1, 1'b0, AW'(16'h0100 + 16'(i * 16)), 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);

        // Underflow, FAULT ignores branch, then clear
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0077, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        // Clear in RUN has no effect
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);

        // Wrap at all-ones, and a return address that wraps to zero
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0100, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);

        // Simultaneous call and ret: ret wins
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0021, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0050, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0099, 1'b0);

        // Stall overrides branch
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0300, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0300, 1'b0);

        // Branch 0x0005 -> 0x0030 (source captured when tracing is built in)
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0005, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0030, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            tg  = AW'($urandom);
            if ($urandom_range(0, 7) == 0) tg = 16'hFFFF;
            st  = ($urandom_range(0, 7) == 0);
            rt  = ($urandom_range(0, 3) == 0);
            cl  = ($urandom_range(0, 2) == 0);
            br  = ($urandom_range(0, 1) == 1);
            clr = ($urandom_range(0, 4) == 0);
            step(st, rt, cl, br, tg, clr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised instruction-pointer unit for the MiniAlu family of cores; replaces the single-register return buffer with a multi-level hardware return-address stack.
- Sits between the decode stage and the instruction ROM address input.
- Supports sequential fetch, stall, jump/branch, nested CALL/RET and fault detection with halt.
- Drives the ROM address directly from a registered IP.

Parameters:
ADDR_W, 16, width of IP, target and return addresses
STACK_DEPTH, 8, number of return-address entries (power of two, 2..64)
RESET_VECTOR, 0, IP value loaded on Reset and on fault clear

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high; clears all state immediately
iStall  in  1  hold IP; no stack activity this cycle
iBranchTaken  in  1  load iTarget into IP (JMP, BGE/BLE taken)
iCall  in  1  push return address, load iTarget
iRet  in  1  pop stack top into IP
iTarget  in  ADDR_W  destination for branch/call
iClearFault  in  1  leave FAULT, IP <= RESET_VECTOR, stack emptied
oIP  out  ADDR_W  current instruction address (registered)
oDepth  out  clog2(STACK_DEPTH)+1  current number of stacked entries
oOverflow  out  1  one-cycle pulse: CALL with stack full
oUnderflow  out  1  one-cycle pulse: RET with stack empty
oFault  out  1  high while in FAULT state

Behaviour:
- Reset (asynchronous, active-high): oIP=RESET_VECTOR, oDepth=0, oOverflow=0, oUnderflow=0, oFault=0, state=RUN. Reset asserted mid-operation aborts any push/pop; stack contents are don't-care once oDepth=0.
- State machine, two states:
  - RUN: normal sequencing.
  - FAULT: entered on overflow or underflow. IP frozen, all control inputs ignored except iClearFault. iClearFault in FAULT -> next cycle RUN, oIP=RESET_VECTOR, oDepth=0. iClearFault in RUN is ignored.
- RUN, per rising edge; priority is iStall > iRet > iCall > iBranchTaken > sequential:
  - iStall=1: oIP and oDepth unchanged.
  - iRet: if oDepth>0, oIP <= stack[oDepth-1] and oDepth decrements. If oDepth=0, oUnderflow pulses for 1 cycle, go to FAULT, oIP unchanged.
  - iCall: if oDepth<STACK_DEPTH, stack[oDepth] <= oIP+1, oIP <= iTarget, oDepth increments. If full, oOverflow pulses for 1 cycle, go to FAULT, no push, oIP unchanged.
  - iBranchTaken: oIP <= iTarget.
  - Otherwise: oIP <= oIP+1.
- Arithmetic: all IP arithmetic is modulo 2^ADDR_W. IP at all-ones wraps to 0. A return address computed at all-ones is pushed as 0.
- Simultaneous iCall and iRet: only iRet is honoured (priority); iCall is dropped silently.
- Latency: control inputs sampled at edge N take effect on oIP after edge N. ROM sees the new address in cycle N+1.
- Fault pulses oOverflow/oUnderflow are registered and high exactly one cycle. oFault stays high for the whole FAULT state.
- Stack is register-based with synchronous write; push and pop never occur in the same cycle.

Optional Feature:
PC_SEQ_TRACE_EN
- Defined: adds output oLastFrom (ADDR_W). On every taken control transfer in RUN (branch, call, successful ret), oLastFrom captures the oIP value before the transfer. Reset value is RESET_VECTOR. It holds during stall and FAULT.
- Undefined: the port and its register are absent. All other behaviour is identical.

Test Plan:
- Reset, then 5 idle cycles -> oIP = 0,1,2,3,4,5; oDepth=0. Assert Reset asynchronously mid-cycle -> oIP=0 immediately, without waiting for a clock edge.
- At oIP=0x0010 pulse iCall with iTarget=0x0040, run 3 cycles, pulse iRet -> oIP = 0x0040,41,42,43, then 0x0011; oDepth goes 1 then 0.
- Nested calls with STACK_DEPTH=8: 8 iCalls succeed (oDepth=8). The 9th iCall -> oOverflow high for 1 cycle, oFault=1, oIP frozen. Pulse iClearFault -> oIP=0, oDepth=0, oFault=0.
- iRet at oDepth=0 -> oUnderflow pulses once, oFault=1. Further iBranchTaken is ignored while in FAULT.
- oIP=0xFFFF with no control -> next oIP=0x0000. iCall at oIP=0xFFFF with iTarget=0x0100, then iRet -> oIP returns to 0x0000.
- Assert iCall+iRet together at oDepth=1, top entry=0x0022 -> oIP=0x0022, oDepth=0. iStall with iBranchTaken -> oIP unchanged. With PC_SEQ_TRACE_EN defined: a branch from 0x0005 to 0x0030 -> oLastFrom=0x0005.
